neander_x_datapath: RTL
=======================

# neander_x_datapath

Register-transfer datapath for the NEANDER-X CPU, placed directly downstream of the `neander_control` FSM. Each cycle it executes that FSM's control strobes. It holds PC, AC, SP, REM, RDM, RI and the N/Z flags, and drives the unified memory and I/O ports. It feeds `opcode`, `sub_opcode`, `flagN` and `flagZ` back to the control FSM.

## Interface
Parameters:
- `SP_RESET`, 8'h00: SP value after reset. The first PUSH therefore writes address 0xFF.

Ports:
- `clk`  in  1  single clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-high. It overrides every load in the same cycle.
- `mem_read, mem_write, pc_inc, pc_load, ac_load, ri_load, rem_load, rdm_load, nz_load, io_write, sp_inc, sp_dec, mem_data_sel`  in  1 each  control strobes from the control FSM.
- `addr_sel`  in  2  REM source: 00=RDM, 01=PC, 10=SP, 11=PC.
- `alu_op`  in  2  00=ADD, 01=AND, 10=OR, 11=NOT.
- `opcode`  out  4  RI[7:4].
- `sub_opcode`  out  4  RI[3:0].
- `flagN`, `flagZ`  out  1  flag registers.
- `mem_addr`  out  8  equal to REM.
- `mem_wdata`  out  8  PC when `mem_data_sel`=1, otherwise AC.
- `mem_we`  out  1  equal to `mem_write` (combinational).
- `mem_re`  out  1  equal to `mem_read` (combinational).
- `mem_rdata`  in  8  combinational read of `mem_addr`; valid in the same cycle.
- `io_in`  in  8  input port data.
- `io_addr`  out  8  equal to RDM (the port number).
- `io_out`  out  8  registered output port.
- `io_out_valid`  out  1  one-cycle pulse.

## Operation
- Reset value of every register is 0x00, except SP = `SP_RESET`.
  - Flags reset to N=0, Z=0.
  - `io_out` resets to 0x00 and `io_out_valid` to 0.
- `rem_load`: REM <= the source selected by `addr_sel`.
- `rdm_load`: RDM <= `mem_rdata`.
- `ri_load`: RI <= RDM.
- PC:
  - `pc_load`: PC <= RDM.
  - `pc_inc` otherwise: PC <= PC+1, wrapping from 0xFF to 0x00.
  - `pc_load` has priority when both are high.
- SP:
  - `sp_dec`: SP-1, wrapping from 0x00 to 0xFF.
  - `sp_inc`: SP+1, wrapping from 0xFF to 0x00.
  - Both high: SP holds.
- AC source on `ac_load` is chosen by decoding `opcode`:
  - 0x2 (LDA), 0xE (LDI), 0x7 (POP): `mem_rdata`.
  - 0xC (IN): `io_in`.
  - 0x3, 0x4, 0x5, 0x6: ALU result.
  - Any other opcode: the ALU result.
- ALU: operand A is AC, operand B is `mem_rdata`.
  - ADD is modulo 256, with no carry kept.
  - NOT is ~AC and ignores B.
- `nz_load`: flags are computed from `ac_next`, the value AC holds after this edge (unchanged AC if `ac_load`=0).
  - N <= `ac_next`[7].
  - Z <= (`ac_next` == 0).
- `io_write`: `io_out` <= AC and `io_out_valid` <= 1 for exactly one cycle; otherwise `io_out_valid` is 0.
- Simultaneous strobes read pre-edge register values. In particular:
  - `mem_write` with `mem_data_sel` and `pc_load` writes the old PC and loads PC from RDM.
  - `ri_load` together with `pc_inc` captures the current RDM.

## Timing
- Register updates take effect at the next edge. Outputs derived from registers change one cycle after the strobe.
- Memory read: REM is loaded at edge k and `mem_rdata` is used during cycle k+1. Zero added latency.
- Memory write is committed by memory at the edge where `mem_we`=1, using the current `mem_addr` and `mem_wdata`.
- `io_out_valid` rises one cycle after `io_write` is sampled.
- Reset asserted mid-instruction: all registers return to reset values at that edge. `mem_we` still follows `mem_write` combinationally, so the FSM must be reset in the same cycle.

## Structure
- Shared package `neander_x_pkg` holds:
  - opcode constants (LDA=2, STA=1, ADD=3, OR=4, AND=5, NOT=6, STACK=7, JMP=8, JN=9, JZ=A, JNZ=B, IN=C, OUT=D, LDI=E, HLT=F);
  - stack sub-opcodes PUSH=0, POP=1, CALL=2, RET=3;
  - `addr_sel_t` and `alu_op_t` enums;
  - the default for `SP_RESET`.
- One sub-module, `neander_x_alu`: combinational, 8-bit inputs A and B, `alu_op`, 8-bit result.

## Test plan
- Fetch: reset, mem[0]=0x23; strobe `rem_load`/`addr_sel`=01, then `rdm_load`, then `ri_load`+`pc_inc` -> `opcode`=2, `sub_opcode`=3, PC=0x01.
- LDA/ADD flags:
  - AC loaded with 0x7F via opcode 2; then with `opcode`=3, `alu_op`=00, `mem_rdata`=0x01, `ac_load`+`nz_load` -> AC=0x80, N=1, Z=0.
  - Then `mem_rdata`=0x80 -> AC=0x00, N=0, Z=1.
- PUSH/POP wrap:
  - From reset, `sp_dec`, then `addr_sel`=10+`rem_load`, then `mem_write` -> `mem_addr`=0xFF, `mem_wdata`=AC.
  - `sp_inc` -> SP=0x00.
  - `sp_inc`+`sp_dec` together -> SP unchanged.
- CALL: PC=0x10, RDM=0x40, SP=0xFF; `mem_write`+`mem_data_sel`+`pc_load` -> `mem_wdata`=0x10 during the cycle, PC=0x40 after the edge.
- PC priority/wrap: PC=0xFF with `pc_inc` -> 0x00; `pc_inc`+`pc_load` with RDM=0x33 -> PC=0x33.
- I/O and reset:
  - `io_write` with AC=0x5A -> `io_out`=0x5A, `io_out_valid` high for exactly one cycle.
  - Opcode C with `io_in`=0xF0 and `ac_load`+`nz_load` -> AC=0xF0, N=1.
  - `reset` asserted mid-sequence -> all registers 0x00 and SP=`SP_RESET` next cycle.

Source files
------------

// File: rtl/neander_x_pkg.sv
// Shared NEANDER-X definitions: opcodes, stack sub-opcodes, datapath selector enums
// and the default stack pointer reset value.
package neander_x_pkg;

   localparam logic [3:0] OP_STA   = 4'h1;
   localparam logic [3:0] OP_LDA   = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_OR    = 4'h4;
   localparam logic [3:0] OP_AND   = 4'h5;
   localparam logic [3:0] OP_NOT   = 4'h6;
   localparam logic [3:0] OP_STACK = 4'h7;
   localparam logic [3:0] OP_JMP   = 4'h8;
   localparam logic [3:0] OP_JN    = 4'h9;
   localparam logic [3:0] OP_JZ    = 4'hA;
   localparam logic [3:0] OP_JNZ   = 4'hB;
   localparam logic [3:0] OP_IN    = 4'hC;
   localparam logic [3:0] OP_OUT   = 4'hD;
   localparam logic [3:0] OP_LDI   = 4'hE;
   localparam logic [3:0] OP_HLT   = 4'hF;

   localparam logic [3:0] SUB_PUSH = 4'h0;
   localparam logic [3:0] SUB_POP  = 4'h1;
   localparam logic [3:0] SUB_CALL = 4'h2;
   localparam logic [3:0] SUB_RET  = 4'h3;

   typedef enum logic [1:0] {
      ADDR_RDM = 2'b00,
      ADDR_PC  = 2'b01,
      ADDR_SP  = 2'b10,
      ADDR_PC2 = 2'b11
   } addr_sel_t;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_AND = 2'b01,
      ALU_OR  = 2'b10,
      ALU_NOT = 2'b11
   } alu_op_t;

   localparam logic [7:0] SP_RESET_DEFAULT = 8'h00;

endpackage

// File: rtl/neander_x_datapath_if.sv
// Unified memory and I/O port bundle between the NEANDER-X datapath and its memory/IO side.
interface neander_x_datapath_if;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_we;
   logic       mem_re;
   logic [7:0] mem_rdata;
   logic [7:0] io_in;
   logic [7:0] io_addr;
   logic [7:0] io_out;
   logic       io_out_valid;

   modport master (
      output mem_addr, mem_wdata, mem_we, mem_re, io_addr, io_out, io_out_valid,
      input  mem_rdata, io_in
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_we, mem_re, io_addr, io_out, io_out_valid,
      output mem_rdata, io_in
   );
endinterface

// File: rtl/neander_x_alu.sv
// Combinational 8-bit ALU; ADD drops the carry, NOT ignores operand B.
module neander_x_alu
   import neander_x_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  alu_op_t    alu_op,
   output logic [7:0] y
);

   always_comb begin
      y = a + b;
      case (alu_op)
         ALU_ADD: y = a + b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_NOT: y = ~a;
         default: y = a + b;
      endcase
   end

endmodule

// File: rtl/neander_x_datapath.sv
// NEANDER-X register-transfer datapath: executes the control FSM strobes each cycle
// and feeds opcode/flags back to it.
module neander_x_datapath
   import neander_x_pkg::*;
#(
   parameter logic [7:0] SP_RESET = SP_RESET_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mem_read,
   input  logic       mem_write,
   input  logic       pc_inc,
   input  logic       pc_load,
   input  logic       ac_load,
   input  logic       ri_load,
   input  logic       rem_load,
   input  logic       rdm_load,
   input  logic       nz_load,
   input  logic       io_write,
   input  logic       sp_inc,
   input  logic       sp_dec,
   input  logic       mem_data_sel,
   input  logic [1:0] addr_sel,
   input  logic [1:0] alu_op,
   output logic [3:0] opcode,
   output logic [3:0] sub_opcode,
   output logic       flagN,
   output logic       flagZ,
   neander_x_datapath_if.master bus
);

   logic [7:0] pc, ac, sp, rem, rdm, ri;
   logic [7:0] io_out_q;
   logic       io_vld_q;
   logic [7:0] alu_y, ac_src, ac_next, rem_src;

   neander_x_alu u_alu (
      .a      (ac),
      .b      (bus.mem_rdata),
      .alu_op (alu_op_t'(alu_op)),
      .y      (alu_y)
   );

   assign opcode     = ri[7:4];
   assign sub_opcode = ri[3:0];

   assign bus.mem_addr     = rem;
   assign bus.mem_wdata    = mem_data_sel ? pc : ac;
   assign bus.mem_we       = mem_write;
   assign bus.mem_re       = mem_read;
   assign bus.io_addr      = rdm;
   assign bus.io_out       = io_out_q;
   assign bus.io_out_valid = io_vld_q;

   // Loads, POP and IN bypass the ALU; everything else takes the ALU result.
   always_comb begin
      ac_src = alu_y;
      case (opcode)
         OP_LDA, OP_LDI, OP_STACK: ac_src = bus.mem_rdata;
         OP_IN:                    ac_src = bus.io_in;
         default:                  ac_src = alu_y;
      endcase
      ac_next = ac_load ? ac_src : ac;
   end

   always_comb begin
      rem_src = pc;
      case (addr_sel_t'(addr_sel))
         ADDR_RDM: rem_src = rdm;
         ADDR_SP:  rem_src = sp;
         default:  rem_src = pc;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= 8'h00;
         ac       <= 8'h00;
         sp       <= SP_RESET;
         rem      <= 8'h00;
         rdm      <= 8'h00;
         ri       <= 8'h00;
         flagN    <= 1'b0;
         flagZ    <= 1'b0;
         io_out_q <= 8'h00;
         io_vld_q <= 1'b0;
      end else begin
         if (rem_load) rem <= rem_src;
         if (rdm_load) rdm <= bus.mem_rdata;
         if (ri_load)  ri  <= rdm;

         if (pc_load)     pc <= rdm;
         else if (pc_inc) pc <= pc + 8'd1;

         // Opposing SP strobes cancel out.
         if (sp_inc && !sp_dec)      sp <= sp + 8'd1;
         else if (sp_dec && !sp_inc) sp <= sp - 8'd1;

         ac <= ac_next;
         if (nz_load) begin
            flagN <= ac_next[7];
            flagZ <= (ac_next == 8'h00);
         end

         io_vld_q <= io_write;
         if (io_write) io_out_q <= ac;
      end
   end

endmodule
